// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, response and memory bus bundle for dmem_arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [1:0]        req_size0;
  logic [1:0]        req_size1;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [31:0]       req_wdata0;
  logic [31:0]       req_wdata1;
  logic [1:0]        rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size0, req_size1, req_addr0, req_addr1,
           req_wdata0, req_wdata1, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req_valid, req_we, req_size0, req_size1, req_addr0, req_addr1,
           req_wdata0, req_wdata1, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter and RMW sequencer for big-endian data memory
module dmem_arbiter #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 32
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t r_state;
  state_t w_next;

  logic              r_last_grant;
  logic              r_port;
  logic              r_we;
  logic              r_err;
  logic [1:0]        r_size;
  logic [1:0]        r_off;
  logic [15:0]       r_wdata;
  logic [31:0]       r_word;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic              w_accept;
  logic              w_grant;
  logic              w_we;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_err;
  logic [4:0]        w_shift;
  logic [31:0]       w_merged;
  logic [31:0]       w_extract;

  // Port selection: alternate when both ask, otherwise serve whoever asks.
  always_comb begin
    w_accept = (r_state == IDLE) && (|bus.req_valid) && !rst;
    if (&bus.req_valid) w_grant = ~r_last_grant;
    else                w_grant = bus.req_valid[1];
    w_we    = bus.req_we[w_grant];
    w_size  = w_grant ? bus.req_size1  : bus.req_size0;
    w_addr  = w_grant ? bus.req_addr1  : bus.req_addr0;
    w_wdata = w_grant ? bus.req_wdata1 : bus.req_wdata0;
    w_err   = (w_size == 2'b11)
            || ((w_size == 2'b01) && w_addr[0])
            || ((w_size == 2'b10) && (|w_addr[1:0]))
            || (w_addr >= ADDR_W'(MEM_BYTES));
  end

  // Big-endian lanes: byte offset 0 is the most significant byte.
  always_comb begin
    w_shift  = 5'd0;
    w_merged = bus.mem_rdata;
    if (r_size == 2'b00) begin
      w_shift  = {~r_off, 3'b000};
      w_merged = (bus.mem_rdata & ~(32'h0000_00FF << w_shift))
               | ({24'd0, r_wdata[7:0]} << w_shift);
    end else if (r_size == 2'b01) begin
      w_shift  = {~r_off[1], 4'b0000};
      w_merged = (bus.mem_rdata & ~(32'h0000_FFFF << w_shift))
               | ({16'd0, r_wdata} << w_shift);
    end
  end

  always_comb begin
    unique case (r_size)
      2'b00:   w_extract = {24'd0, 8'(r_word >> {~r_off, 3'b000})};
      2'b01:   w_extract = r_off[1] ? {16'd0, r_word[15:0]} : {16'd0, r_word[31:16]};
      default: w_extract = r_word;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_err)                           w_next = RESP;
          else if (w_we && (w_size == 2'b10))  w_next = WRITE;
          else                                 w_next = READ;
        end
      end
      READ:    w_next = r_we ? WRITE : RESP;
      WRITE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_size       <= 2'b00;
      r_off        <= 2'b00;
      r_wdata      <= 16'd0;
      r_word       <= 32'd0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant;
        r_port       <= w_grant;
        r_we         <= w_we;
        r_err        <= w_err;
        r_size       <= w_size;
        r_off        <= w_addr[1:0];
        r_wdata      <= w_wdata[15:0];
        // Rejected requests leave the memory-facing registers untouched.
        if (!w_err) begin
          r_mem_addr <= 32'({w_addr[ADDR_W-1:2], 2'b00});
          if (w_we && (w_size == 2'b10)) r_mem_wdata <= w_wdata;
        end
      end
      if (r_state == READ) begin
        r_word <= bus.mem_rdata;
        if (r_we) r_mem_wdata <= w_merged;
      end
    end
  end

  assign bus.req_ready = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_valid = (r_state == RESP) ? (r_port ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_err   = (r_state == RESP) && r_err;
  assign bus.rsp_rdata = ((r_state == RESP) && !r_we && !r_err) ? w_extract : 32'd0;
  assign bus.mem_read  = (r_state == READ);
  assign bus.mem_write = (r_state == WRITE);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with byte-level memory reference
module tb_dmem_arbiter;
  localparam int MEM_BYTES = 256;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32)) ifc ();

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic [1:0]  rv = 2'b00;
  logic [1:0]  rwe = 2'b00;
  logic [1:0]  rsz [2];
  logic [31:0] raddr [2];
  logic [31:0] rwdata [2];

  assign ifc.req_valid  = rv;
  assign ifc.req_we     = rwe;
  assign ifc.req_size0  = rsz[0];
  assign ifc.req_size1  = rsz[1];
  assign ifc.req_addr0  = raddr[0];
  assign ifc.req_addr1  = raddr[1];
  assign ifc.req_wdata0 = rwdata[0];
  assign ifc.req_wdata1 = rwdata[1];

  logic [7:0] dev_mem [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  logic [7:0] w_ma;
  assign w_ma = ifc.mem_addr[7:0];
  assign ifc.mem_rdata = ifc.mem_read
      ? {dev_mem[w_ma], dev_mem[w_ma + 8'd1], dev_mem[w_ma + 8'd2], dev_mem[w_ma + 8'd3]}
      : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (ifc.mem_write) begin
      dev_mem[w_ma]        <= ifc.mem_wdata[31:24];
      dev_mem[w_ma + 8'd1] <= ifc.mem_wdata[23:16];
      dev_mem[w_ma + 8'd2] <= ifc.mem_wdata[15:8];
      dev_mem[w_ma + 8'd3] <= ifc.mem_wdata[7:0];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_reads = 0, exp_writes = 0, act_reads = 0, act_writes = 0;
  logic exp_last = 1'b1;
  bit abort_next = 1'b0;
  logic [31:0] last_rdata = 32'd0;
  logic [31:0] last_wdata = 32'd0;
  rsp_t sbq [$];
  wr_t  wq [$];
  int   grant_log [$];
  req_t pq0 [$];
  req_t pq1 [$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s", name);
  endfunction

  // Reference: plain byte array, big-endian, right-justified data.
  task automatic model_accept(input int p, input int c);
    logic [1:0]  sz = rsz[p];
    logic [31:0] a  = raddr[p];
    logic [31:0] d  = rwdata[p];
    logic        we = rwe[p];
    int          nb = 1 << sz;
    int          base;
    rsp_t        e;
    wr_t         w;
    e.port  = p;
    e.acc   = c;
    e.rdata = 32'd0;
    e.err   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
            || (a >= 32'(MEM_BYTES));
    if (e.err) begin
      e.lat = 1;
    end else if (!we) begin
      e.lat = 2;
      exp_reads++;
      for (int i = 0; i < nb; i++) e.rdata = {e.rdata[23:0], ref_mem[int'(a[7:0]) + i]};
    end else begin
      e.lat = (sz == 2'd2) ? 2 : 3;
      if (sz != 2'd2) exp_reads++;
      exp_writes++;
      for (int i = 0; i < nb; i++) ref_mem[int'(a[7:0]) + i] = d[8*(nb-1-i) +: 8];
      base   = int'(a[7:0]) & ~3;
      w.addr = 32'(base);
      w.data = {ref_mem[base], ref_mem[base+1], ref_mem[base+2], ref_mem[base+3]};
      wq.push_back(w);
    end
    sbq.push_back(e);
  endtask

  initial begin : accept_monitor
    int p, g;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_last = 1'b1;
      end else if (ifc.req_ready != 2'b00) begin
        check("ready_onehot", 32'($countones(ifc.req_ready)), 32'd1);
        p = ifc.req_ready[1] ? 1 : 0;
        if (rv == 2'b11) g = exp_last ? 0 : 1;
        else             g = rv[1] ? 1 : 0;
        check("grant", 32'(p), 32'(g));
        exp_last = p[0];
        grant_log.push_back(p);
        if (abort_next) abort_next = 1'b0;
        else            model_accept(p, cyc);
      end
    end
  end

  initial begin : response_monitor
    rsp_t e;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ifc.mem_read || ifc.mem_write)
          check("strobe_exclusive", {31'd0, ifc.mem_read & ifc.mem_write}, 32'd0);
        if (ifc.mem_read) act_reads++;
        if (ifc.mem_write) begin
          act_writes++;
          if (wq.size() == 0) fail_now("unexpected_write");
          else begin
            w = wq.pop_front();
            check("wr_addr", ifc.mem_addr, w.addr);
            check("wr_data", ifc.mem_wdata, w.data);
            last_wdata = ifc.mem_wdata;
          end
        end
        if (ifc.rsp_valid != 2'b00) begin
          if (sbq.size() == 0) fail_now("unexpected_rsp");
          else begin
            e = sbq.pop_front();
            check("rsp_port", {30'd0, ifc.rsp_valid}, (e.port == 1) ? 32'd2 : 32'd1);
            check("rsp_err", {31'd0, ifc.rsp_err}, {31'd0, e.err});
            check("rsp_rdata", ifc.rsp_rdata, e.rdata);
            check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
            last_rdata = ifc.rsp_rdata;
          end
        end
      end
    end
  end

  task automatic add(input int p, input logic we, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.we = we; r.size = sz; r.addr = a; r.wdata = d;
    if (p == 0) pq0.push_back(r);
    else        pq1.push_back(r);
  endtask

  task automatic load_port(input int p, input req_t r);
    rv[p]     = 1'b1;
    rwe[p]    = r.we;
    rsz[p]    = r.size;
    raddr[p]  = r.addr;
    rwdata[p] = r.wdata;
  endtask

  task automatic run(input int gap_max, input int budget);
    int t = 0;
    logic [1:0] acc;
    while ((pq0.size() > 0 || pq1.size() > 0 || rv != 2'b00) && t < budget) begin
      @(negedge clk);
      acc = ifc.req_ready;
      @(posedge clk);
      #1;
      if (acc[0]) rv[0] = 1'b0;
      if (acc[1]) rv[1] = 1'b0;
      if (!rv[0] && pq0.size() > 0 && $urandom_range(gap_max, 0) == 0) load_port(0, pq0.pop_front());
      if (!rv[1] && pq1.size() > 0 && $urandom_range(gap_max, 0) == 0) load_port(1, pq1.pop_front());
      t++;
    end
    if (t >= budget) fail_now("run_timeout");
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() != 0) fail_now("drain_timeout");
    #1;
  endtask

  initial begin : main
    logic [31:0] w14;
    logic [31:0] a;
    logic [1:0]  sz;
    int          diffs;
    rsz[0] = 2'd0; rsz[1] = 2'd0;
    raddr[0] = 32'd0; raddr[1] = 32'd0;
    rwdata[0] = 32'd0; rwdata[1] = 32'd0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end

    // Reset state, with a request presented to confirm ready stays low.
    rv = 2'b01; rsz[0] = 2'd2; raddr[0] = 32'h10;
    repeat (3) @(posedge clk);
    #2;
    check("rst_req_ready", {30'd0, ifc.req_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, ifc.rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, ifc.rsp_err}, 32'd0);
    check("rst_mem_read", {31'd0, ifc.mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, ifc.mem_write}, 32'd0);
    check("rst_rsp_rdata", ifc.rsp_rdata, 32'd0);
    check("rst_mem_addr", ifc.mem_addr, 32'd0);
    check("rst_mem_wdata", ifc.mem_wdata, 32'd0);
    rv = 2'b00;
    rst = 1'b0;

    add(0, 1'b1, 2'd2, 32'h14, 32'h1122_3344);
    add(0, 1'b0, 2'd2, 32'h14, 32'd0);
    run(0, 100);
    check("t1_word_load", last_rdata, 32'h1122_3344);

    add(0, 1'b1, 2'd0, 32'h15, 32'h0000_00AB);
    run(0, 100);
    check("t2_byte_merge", last_wdata, 32'h11AB_3344);
    add(0, 1'b0, 2'd0, 32'h15, 32'd0);
    run(0, 100);
    check("t2_byte_load", last_rdata, 32'h0000_00AB);

    add(0, 1'b1, 2'd1, 32'h16, 32'h0000_BEEF);
    run(0, 100);
    check("t3_half_merge", last_wdata, 32'h11AB_BEEF);
    add(0, 1'b0, 2'd1, 32'h16, 32'd0);
    run(0, 100);
    check("t3_half_load", last_rdata, 32'h0000_BEEF);

    add(1, 1'b0, 2'd2, 32'h20, 32'd0);
    run(0, 100);
    grant_log.delete();
    add(0, 1'b0, 2'd2, 32'h14, 32'd0);
    add(0, 1'b1, 2'd2, 32'h40, 32'hCAFE_0001);
    add(1, 1'b0, 2'd2, 32'h18, 32'd0);
    add(1, 1'b1, 2'd0, 32'h43, 32'h0000_0077);
    run(0, 100);
    check("t4_grant_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4)
      check("t4_grant_order", {grant_log[0][7:0], grant_log[1][7:0], grant_log[2][7:0], grant_log[3][7:0]},
            32'h0001_0001);

    diffs = act_reads + act_writes;
    add(0, 1'b0, 2'd1, 32'h13, 32'd0);
    add(0, 1'b1, 2'd2, 32'h102, 32'hFFFF_FFFF);
    add(1, 1'b0, 2'd3, 32'h20, 32'd0);
    run(0, 100);
    check("t5_no_strobes", 32'(act_reads + act_writes - diffs), 32'd0);
    check("t5_last_err_rdata", last_rdata, 32'd0);

    // Reset while a byte store sits in READ.
    w14 = {dev_mem[8'h14], dev_mem[8'h15], dev_mem[8'h16], dev_mem[8'h17]};
    @(posedge clk);
    #1;
    abort_next = 1'b1;
    rv[0] = 1'b1; rwe[0] = 1'b1; rsz[0] = 2'd0; raddr[0] = 32'h15; rwdata[0] = 32'h5A;
    @(negedge clk);
    check("t6_ready", {30'd0, ifc.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    rv = 2'b00;
    check("t6_in_read", {31'd0, ifc.mem_read}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_read", {31'd0, ifc.mem_read}, 32'd0);
    check("t6_rst_write", {31'd0, ifc.mem_write}, 32'd0);
    check("t6_rst_rsp", {30'd0, ifc.rsp_valid}, 32'd0);
    check("t6_rst_addr", ifc.mem_addr, 32'd0);
    check("t6_rst_wdata", ifc.mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("t6_word_kept", {dev_mem[8'h14], dev_mem[8'h15], dev_mem[8'h16], dev_mem[8'h17]}, w14);
    grant_log.delete();
    add(0, 1'b0, 2'd2, 32'h14, 32'd0);
    add(1, 1'b0, 2'd2, 32'h14, 32'd0);
    run(0, 100);
    check("t6_first_grant", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'd0);

    for (int n = 0; n < 300; n++) begin
      sz = ($urandom_range(15, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
      a  = ($urandom_range(99, 0) < 8) ? 32'(256 + $urandom_range(300, 0)) : 32'($urandom_range(255, 0));
      if ($urandom_range(9, 0) < 7) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      add(n % 2, 1'($urandom), sz, a, $urandom);
    end
    run(2, 5000);

    diffs = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (dev_mem[i] !== ref_mem[i]) diffs++;
    check("final_mem_diff_bytes", 32'(diffs), 32'd0);
    check("final_reads", 32'(act_reads), 32'(exp_reads));
    check("final_writes", 32'(act_writes), 32'(exp_writes));
    check("final_wq_empty", 32'(wq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

endmodule
